register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 59 +++++
 tb/tb_register_file.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Two-read, one-write general register file with registered Z/N status flags.
// Reads are purely combinational from the stored array; writes land on the clock edge.
module register_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     aa_in,
    input  logic [AW-1:0]     ba_in,
    input  logic [AW-1:0]     da_in,
    input  logic              rw_in,
    input  logic [DATA_W-1:0] d_in,
    input  logic              fl_we_in,
    input  logic              z_in,
    input  logic              n_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              z_flag_out,
    output logic              n_flag_out
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  wr_sel;

    // Per-register enables keep unaddressed entries untouched even with X on da_in/d_in.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_sel[i] = rw_in && (da_in == AW'(i));
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                regs[g] <= '0;
            end else if (wr_sel[g]) begin
                regs[g] <= d_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_flag_out <= 1'b0;
            n_flag_out <= 1'b0;
        end else if (fl_we_in) begin
            z_flag_out <= z_in;
            n_flag_out <= n_in;
        end
    end

    // No bypass from d_in: a same-cycle read returns the pre-edge contents.
    assign a_out = regs[aa_in];
    assign b_out = regs[ba_in];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios then randomized
// traffic compared against an array-based reference model.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [2:0]  aa_in;
    logic [2:0]  ba_in;
    logic [2:0]  da_in;
    logic        rw_in;
    logic [15:0] d_in;
    logic        fl_we_in;
    logic        z_in;
    logic        n_in;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic        z_flag_out;
    logic        n_flag_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] mr [8];
    logic        mz;
    logic        mn;

    register_file #(.DATA_W(16), .NREGS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .aa_in     (aa_in),
        .ba_in     (ba_in),
        .da_in     (da_in),
        .rw_in     (rw_in),
        .d_in      (d_in),
        .fl_we_in  (fl_we_in),
        .z_in      (z_in),
        .n_in      (n_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .z_flag_out(z_flag_out),
        .n_flag_out(n_flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and apply the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
            mz = 1'b0;
            mn = 1'b0;
        end else begin
            if (rw_in) mr[da_in] = d_in;
            if (fl_we_in) begin
                mz = z_in;
                mn = n_in;
            end
        end
        #1;
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, "_a"}, a_out, mr[aa_in]);
        check({tag, "_b"}, b_out, mr[ba_in]);
        check({tag, "_z"}, {15'd0, z_flag_out}, {15'd0, mz});
        check({tag, "_n"}, {15'd0, n_flag_out}, {15'd0, mn});
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        rw_in = 1'b1;
        da_in = a;
        d_in  = d;
        tick();
        rw_in = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b0; aa_in = '0; ba_in = '0; da_in = '0; rw_in = 1'b0;
        d_in = '0; fl_we_in = 1'b0; z_in = 1'b0; n_in = 1'b0;
        for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
        mz = 1'b0; mn = 1'b0;
        @(negedge clk);

        // Reset then sweep both read ports.
        rst = 1'b1; rw_in = 1'b1; fl_we_in = 1'b1; z_in = 1'b1; n_in = 1'b1;
        tick();
        rst = 1'b0; rw_in = 1'b0; fl_we_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            aa_in = 3'(i);
            ba_in = 3'(7 - i);
            #1;
            check("rst_a", a_out, 16'h0000);
            check("rst_b", b_out, 16'h0000);
        end
        check("rst_z", {15'd0, z_flag_out}, 16'h0000);
        check("rst_n", {15'd0, n_flag_out}, 16'h0000);

        // Write R3 and read back; old value during the write cycle.
        aa_in = 3'd3; ba_in = 3'd3;
        rw_in = 1'b1; da_in = 3'd3; d_in = 16'hBEEF;
        #1;
        check("raw_a", a_out, 16'h0000);
        check("raw_b", b_out, 16'h0000);
        tick();
        rw_in = 1'b0;
        #1;
        check("wr3_a", a_out, 16'hBEEF);
        check("wr3_b", b_out, 16'hBEEF);

        // Every register, including R0, is writable.
        for (int n = 0; n < 8; n++) write_reg(3'(n), 16'(16'h1111 * n));
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                aa_in = 3'(a);
                ba_in = 3'(b);
                #1;
                check("pair_a", a_out, 16'(16'h1111 * a));
                check("pair_b", b_out, 16'(16'h1111 * b));
            end
        end
        for (int k = 0; k < 4; k++) begin
            rw_in = 1'b0;
            da_in = 3'($urandom_range(0, 7));
            d_in  = 16'($urandom);
            tick();
        end
        da_in = 3'bxxx; d_in = 16'hxxxx; rw_in = 1'b0;
        tick();
        da_in = '0; d_in = '0;
        for (int a = 0; a < 8; a++) begin
            aa_in = 3'(a);
            ba_in = 3'(a);
            #1;
            check("hold_a", a_out, 16'(16'h1111 * a));
            check("hold_b", b_out, 16'(16'h1111 * a));
        end

        // Flags load and hold.
        fl_we_in = 1'b1; z_in = 1'b1; n_in = 1'b0;
        tick();
        check("fl_z", {15'd0, z_flag_out}, 16'h0001);
        check("fl_n", {15'd0, n_flag_out}, 16'h0000);
        fl_we_in = 1'b0; z_in = 1'b0; n_in = 1'b1;
        tick();
        tick();
        check("flh_z", {15'd0, z_flag_out}, 16'h0001);
        check("flh_n", {15'd0, n_flag_out}, 16'h0000);

        // Reset beats a simultaneous write and flag write.
        rst = 1'b1; rw_in = 1'b1; da_in = 3'd5; d_in = 16'h00FF;
        fl_we_in = 1'b1; z_in = 1'b1; n_in = 1'b1;
        tick();
        rst = 1'b0; rw_in = 1'b0; fl_we_in = 1'b0;
        aa_in = 3'd5; ba_in = 3'd2;
        #1;
        check("rprio_r5", a_out, 16'h0000);
        check("rprio_r2", b_out, 16'h0000);
        check("rprio_z", {15'd0, z_flag_out}, 16'h0000);
        check("rprio_n", {15'd0, n_flag_out}, 16'h0000);
        write_reg(3'd5, 16'h1234);
        #1;
        check("post_rst_wr", a_out, 16'h1234);

        // Increment loop through an emulated function unit.
        write_reg(3'd1, 16'hFFFF);
        aa_in = 3'd1; ba_in = 3'd1;
        #1;
        v = a_out + 16'd1;
        d_in = v; z_in = (v == 16'h0000); n_in = v[15];
        rw_in = 1'b1; da_in = 3'd1; fl_we_in = 1'b1;
        #1;
        check("inc_stable", a_out, 16'hFFFF);
        tick();
        rw_in = 1'b0; fl_we_in = 1'b0;
        #1;
        check("inc_r1", a_out, 16'h0000);
        check("inc_z", {15'd0, z_flag_out}, 16'h0001);
        check("inc_n", {15'd0, n_flag_out}, 16'h0000);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 39) == 0);
            rw_in    = 1'($urandom);
            fl_we_in = 1'($urandom);
            da_in    = 3'($urandom_range(0, 7));
            d_in     = 16'($urandom);
            z_in     = 1'($urandom);
            n_in     = 1'($urandom);
            aa_in    = 3'($urandom_range(0, 7));
            ba_in    = 3'($urandom_range(0, 7));
            check_ports("rnd_pre");
            tick();
            rst = 1'b0;
            check_ports("rnd_post");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
